// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// NZCV flag bit positions and a small flag-unpacking helper.
package cond_logic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAG_W_NZ = 1;
  localparam int FLAG_W_CV = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic flags_t unpack_flags(input logic [3:0] raw);
    flags_t f;
    f.n = raw[FLAG_N];
    f.z = raw[FLAG_Z];
    f.c = raw[FLAG_C];
    f.v = raw[FLAG_V];
    return f;
  endfunction

endpackage

// File: rtl/cond_logic_cond_check.sv
// Evaluates a 4-bit condition field against stored NZCV flags.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  flags_t f;
  logic   ge;

  assign f  = unpack_flags(Flags);
  assign ge = (f.n == f.v);

  // NV (and anything unexpected) resolves to a hard 0 so no X leaks to the gates.
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx = f.z;
      COND_NE: CondEx = ~f.z;
      COND_CS: CondEx = f.c;
      COND_CC: CondEx = ~f.c;
      COND_MI: CondEx = f.n;
      COND_PL: CondEx = ~f.n;
      COND_VS: CondEx = f.v;
      COND_VC: CondEx = ~f.v;
      COND_HI: CondEx = f.c & ~f.z;
      COND_LS: CondEx = ~f.c | f.z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~f.z & ge;
      COND_LE: CondEx = f.z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/flopenr.sv
// Generic enabled register with synchronous active-high reset.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Reset wins over the enable so a cleared register never picks up stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV and gates PC/register/memory writes
// and its own flag updates with the evaluated condition.
module cond_logic
  import cond_logic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic       cond_ex;
  logic [1:0] flag_write;
  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic [3:0] flags;

  assign flags = {nz_q, cv_q};

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags),
    .CondEx (cond_ex)
  );

  // The executing instruction sees old flags; its own update lands on the next edge.
  always_comb begin
    flag_write = FlagW & {2{cond_ex}};
  end

  flopenr #(.WIDTH(2)) u_nz_reg (
    .clk   (clk),
    .reset (reset),
    .en    (flag_write[FLAG_W_NZ]),
    .d     (ALUFlags[FLAG_N:FLAG_Z]),
    .q     (nz_q)
  );

  flopenr #(.WIDTH(2)) u_cv_reg (
    .clk   (clk),
    .reset (reset),
    .en    (flag_write[FLAG_W_CV]),
    .d     (ALUFlags[FLAG_C:FLAG_V]),
    .q     (cv_q)
  );

  always_comb begin
    PCSrc    = PCS  & cond_ex;
    RegWrite = RegW & cond_ex;
    MemWrite = MemW & cond_ex;
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed literal checks plus randomized
// traffic compared every cycle against a behavioural flag/condition model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'b1110;
  logic [3:0] ALUFlags = 4'b0000;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0;
  logic       RegW = 1'b0;
  logic       MemW = 1'b0;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;

  int checkCount = 0;
  int errorCount = 0;

  logic [3:0] modelFlags = 4'b0000;
  logic       compareEnable = 1'b0;

  int         litReq = 0;
  int         litDone = 0;
  string      litName;
  logic [2:0] litExp;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

  always #5 clk = ~clk;

  // Condition rules: the upper three bits pick a predicate, bit 0 inverts it,
  // and 1111 never executes.
  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      modelFlags <= 4'b0000;
    end else if (condHolds(Cond, modelFlags)) begin
      if (FlagW[1]) modelFlags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) modelFlags[1:0] <= ALUFlags[1:0];
    end
  end

  // Single compare process: model check every cycle plus any pending literal check.
  always @(negedge clk) begin
    logic ex;
    logic [2:0] act;
    logic [2:0] exp;
    if (compareEnable) begin
      ex  = condHolds(Cond, modelFlags);
      act = {PCSrc, RegWrite, MemWrite};
      exp = {PCS & ex, RegW & ex, MemW & ex};
      checkCount = checkCount + 1;
      if (act !== exp) begin
        errorCount = errorCount + 1;
        $display("[TB] FAIL model t=%0t cond=%b flags=%b got {PCSrc,RegWrite,MemWrite}=%b expected %b",
                 $time, Cond, modelFlags, act, exp);
      end
      if (litReq != litDone) begin
        litDone = litReq;
        checkCount = checkCount + 1;
        if (act !== litExp) begin
          errorCount = errorCount + 1;
          $display("[TB] FAIL %s got {PCSrc,RegWrite,MemWrite}=%b expected %b", litName, act, litExp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                               input logic [1:0] fw, input logic pcs, input logic rw,
                               input logic mw);
    @(posedge clk);
    #1;
    reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw;
  endtask

  task automatic checkOutput(input string name, input logic pc, input logic rw, input logic mw);
    litName = name;
    litExp  = {pc, rw, mw};
    litReq  = litReq + 1;
  endtask

  // Probe one condition with all requests high and no flag write.
  task automatic probe(input string name, input logic [3:0] c, input logic exp);
    applyStimulus(1'b0, c, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    checkOutput(name, exp, exp, exp);
  endtask

  initial begin
    applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    compareEnable = 1'b1;

    applyStimulus(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    checkOutput("al_after_reset", 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    checkOutput("mi_after_reset", 1'b0, 1'b0, 1'b0);
    probe("eq_after_reset", 4'b0000, 1'b0);
    probe("ne_after_reset", 4'b0001, 1'b1);
    probe("ge_after_reset", 4'b1010, 1'b1);

    applyStimulus(1'b0, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0);
    checkOutput("al_set_n", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("mi_n_set", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("pl_n_set", 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 4'b0000, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0);
    checkOutput("eq_suppressed", 1'b0, 1'b0, 1'b0);
    probe("mi_after_suppress", 4'b0100, 1'b1);
    probe("eq_after_suppress", 4'b0000, 1'b0);

    applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1110, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b0);
    probe("hi_cv_only", 4'b1000, 1'b1);
    probe("ls_cv_only", 4'b1001, 1'b0);
    probe("ge_cv_only", 4'b1010, 1'b0);
    probe("lt_cv_only", 4'b1011, 1'b1);

    applyStimulus(1'b0, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0);
    probe("eq_flags_0110", 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0);
    checkOutput("al_during_reset", 1'b0, 1'b1, 1'b0);
    probe("eq_after_midreset", 4'b0000, 1'b0);
    probe("cs_after_midreset", 4'b0010, 1'b0);
    probe("ne_after_midreset", 4'b0001, 1'b1);
    probe("nv_never", 4'b1111, 1'b0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
